// File: rtl/bus_slave_response_unit_pkg.sv
// Shared types, defaults and width helpers for the slave response unit.
package bus_slave_response_unit_pkg;

  localparam int unsigned WORD_DATA_WIDTH         = 32;
  localparam int unsigned BUS_RSP_DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    BUS_RSP_STATE_IDLE = 2'd0,
    BUS_RSP_STATE_WAIT = 2'd1,
    BUS_RSP_STATE_RESP = 2'd2
  } bus_rsp_state_e;

  // Watchdog counter width: enough for 0..TIMEOUT_CYCLES, never below one bit.
  function automatic int unsigned rsp_cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w == 0) ? 1 : w;
  endfunction

  // Slave index width, never below one bit.
  function automatic int unsigned rsp_idx_width(input int unsigned num);
    int unsigned w;
    w = $clog2(num);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_slave_response_unit_if.sv
// Master/slave-side signal bundle of the response unit; all bus strobes active-low.
interface bus_slave_response_unit_if
  import bus_slave_response_unit_pkg::*;
#(
  parameter int unsigned SLAVE_NUM  = 8,
  parameter int unsigned DATA_WIDTH = WORD_DATA_WIDTH
);

  logic                            master_request_;
  logic [SLAVE_NUM-1:0]            slave_chip_select_;
  logic [SLAVE_NUM*DATA_WIDTH-1:0] slave_read_data;
  logic [SLAVE_NUM-1:0]            slave_ready_;
  logic [DATA_WIDTH-1:0]           master_read_data;
  logic                            master_ready_;
  logic                            master_error_;
  logic                            busy_;

  // View of the response unit itself.
  modport slave (
    input  master_request_, slave_chip_select_, slave_read_data, slave_ready_,
    output master_read_data, master_ready_, master_error_, busy_
  );

  // View of the surrounding interconnect (master port plus decoded slaves).
  modport master (
    output master_request_, slave_chip_select_, slave_read_data, slave_ready_,
    input  master_read_data, master_ready_, master_error_, busy_
  );

endinterface

// File: rtl/bus_slave_priority_encoder.sv
// Picks the lowest-index asserted active-low chip select.
module bus_slave_priority_encoder #(
  parameter int unsigned SLAVE_NUM = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [SLAVE_NUM-1:0] chip_select_,
  output logic [IDX_W-1:0]     idx_c,
  output logic                 valid_c
);

  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    for (int i = int'(SLAVE_NUM) - 1; i >= 0; i--) begin
      if (!chip_select_[i]) begin
        idx_c   = IDX_W'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_slave_response_unit.sv
// Registered read-data/ready return path with decode-miss and timeout error responses.
module bus_slave_response_unit
  import bus_slave_response_unit_pkg::*;
#(
  parameter int unsigned SLAVE_NUM      = 8,
  parameter int unsigned DATA_WIDTH     = WORD_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = BUS_RSP_DEFAULT_TIMEOUT
) (
  input logic                    clk,
  input logic                    reset_,
  bus_slave_response_unit_if.slave bus
);

  localparam int unsigned IDX_W = rsp_idx_width(SLAVE_NUM);
  localparam int unsigned CNT_W = rsp_cnt_width(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bus_rsp_state_e        state, state_nx;
  logic [IDX_W-1:0]      idx_q, idx_nx;
  logic [CNT_W-1:0]      cnt_q, cnt_nx;
  logic [DATA_WIDTH-1:0] data_q, data_nx;
  logic                  ready_q, ready_nx;
  logic                  error_q, error_nx;
  logic                  busy_q, busy_nx;

  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_valid;
  logic [DATA_WIDTH-1:0] rd [SLAVE_NUM];

  bus_slave_priority_encoder #(
    .SLAVE_NUM (SLAVE_NUM),
    .IDX_W     (IDX_W)
  ) u_enc (
    .chip_select_ (bus.slave_chip_select_),
    .idx_c        (enc_idx),
    .valid_c      (enc_valid)
  );

  // Unpack the flat read-data bus into per-slave words.
  for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_rd
    assign rd[i] = bus.slave_read_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next state and next registered outputs; response strobes default inactive.
  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    cnt_nx   = cnt_q;
    data_nx  = data_q;
    ready_nx = 1'b1;
    error_nx = 1'b1;
    busy_nx  = 1'b1;
    unique case (state)
      BUS_RSP_STATE_IDLE: begin
        if (!bus.master_request_) begin
          if (!enc_valid) begin
            state_nx = BUS_RSP_STATE_RESP;
            data_nx  = '0;
            ready_nx = 1'b0;
            error_nx = 1'b0;
          end else if (!bus.slave_ready_[enc_idx]) begin
            state_nx = BUS_RSP_STATE_RESP;
            data_nx  = rd[enc_idx];
            ready_nx = 1'b0;
          end else begin
            state_nx = BUS_RSP_STATE_WAIT;
            idx_nx   = enc_idx;
            cnt_nx   = '0;
            busy_nx  = 1'b0;
          end
        end
      end
      BUS_RSP_STATE_WAIT: begin
        if (bus.master_request_) begin
          // Master gave up: drop the access silently.
          state_nx = BUS_RSP_STATE_IDLE;
          cnt_nx   = '0;
        end else if (!bus.slave_ready_[idx_q]) begin
          // Ready beats a coincident timeout.
          state_nx = BUS_RSP_STATE_RESP;
          data_nx  = rd[idx_q];
          ready_nx = 1'b0;
          cnt_nx   = '0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_nx = BUS_RSP_STATE_RESP;
          data_nx  = '0;
          ready_nx = 1'b0;
          error_nx = 1'b0;
          cnt_nx   = '0;
        end else begin
          busy_nx = 1'b0;
          if (cnt_q != CNT_MAX) begin
            cnt_nx = cnt_q + CNT_W'(1);
          end
        end
      end
      BUS_RSP_STATE_RESP: begin
        state_nx = BUS_RSP_STATE_IDLE;
      end
      default: begin
        state_nx = BUS_RSP_STATE_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= BUS_RSP_STATE_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state   <= state_nx;
      idx_q   <= idx_nx;
      cnt_q   <= cnt_nx;
      data_q  <= data_nx;
      ready_q <= ready_nx;
      error_q <= error_nx;
      busy_q  <= busy_nx;
    end
  end

  assign bus.master_read_data = data_q;
  assign bus.master_ready_    = ready_q;
  assign bus.master_error_    = error_q;
  assign bus.busy_            = busy_q;

endmodule

// File: tb/tb_bus_slave_response_unit.sv
// Scoreboard bench: dut_a with an 8-cycle timeout, dut_b with the timeout disabled.
module tb_bus_slave_response_unit;

  localparam int unsigned SN = 8;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err_n;
  } exp_t;

  logic clk;
  logic reset_;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t sb_e;
  logic prev_low = 1'b0;

  bus_slave_response_unit_if #(.SLAVE_NUM(SN), .DATA_WIDTH(DW)) bus_a ();
  bus_slave_response_unit_if #(.SLAVE_NUM(SN), .DATA_WIDTH(DW)) bus_b ();

  bus_slave_response_unit #(.SLAVE_NUM(SN), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut_a (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus_a)
  );

  bus_slave_response_unit #(.SLAVE_NUM(SN), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_b (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard monitor for dut_a, plus strobe sanity checks.
  always @(negedge clk) begin
    if (!bus_a.master_ready_) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: response data %h err_n %b with nothing expected",
                 bus_a.master_read_data, bus_a.master_error_);
      end else begin
        sb_e = sb_q.pop_front();
        n_vec++;
        if (bus_a.master_read_data !== sb_e.data) begin
          n_bad++;
          $display("FAIL sb_data: got %h expected %h", bus_a.master_read_data, sb_e.data);
        end
        n_vec++;
        if (bus_a.master_error_ !== sb_e.err_n) begin
          n_bad++;
          $display("FAIL sb_error: got %b expected %b", bus_a.master_error_, sb_e.err_n);
        end
      end
    end
    if (bus_a.master_ready_ && !bus_a.master_error_) begin
      n_bad++;
      $display("FAIL err_qual: master_error_ low without master_ready_");
    end
    if (!bus_a.master_ready_ && prev_low) begin
      n_bad++;
      $display("FAIL ready_width: master_ready_ low two cycles in a row");
    end
    prev_low = !bus_a.master_ready_;
  end

  task automatic idle_a();
    bus_a.master_request_    = 1'b1;
    bus_a.slave_chip_select_ = '1;
    bus_a.slave_ready_       = '1;
  endtask

  task automatic idle_b();
    bus_b.master_request_    = 1'b1;
    bus_b.slave_chip_select_ = '1;
    bus_b.slave_ready_       = '1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    idle_a();
    idle_b();
    bus_a.slave_read_data = '0;
    bus_b.slave_read_data = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus_a.master_ready_, bus_a.master_error_, bus_a.busy_} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_strobes_a: got %b expected 111",
               {bus_a.master_ready_, bus_a.master_error_, bus_a.busy_});
    end
    n_vec++;
    if (bus_a.master_read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data_a: got %h expected 0", bus_a.master_read_data);
    end
    n_vec++;
    if ({bus_b.master_ready_, bus_b.master_error_, bus_b.busy_} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_strobes_b: got %b expected 111",
               {bus_b.master_ready_, bus_b.master_error_, bus_b.busy_});
    end
    reset_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_direct();
    idle_a();
    bus_a.slave_read_data[3*DW +: DW] = 32'hDEAD_BEEF;
    bus_a.slave_chip_select_[3] = 1'b0;
    bus_a.slave_ready_[3]       = 1'b0;
    bus_a.master_request_       = 1'b0;
    sb_q.push_back('{data: 32'hDEAD_BEEF, err_n: 1'b1});
    @(negedge clk);
    n_vec++;
    if ({bus_a.master_ready_, bus_a.busy_} !== 2'b01) begin
      n_bad++;
      $display("FAIL direct_latency: ready_,busy_ got %b expected 01",
               {bus_a.master_ready_, bus_a.busy_});
    end
    idle_a();
    @(negedge clk);
    n_vec++;
    if ({bus_a.master_ready_, bus_a.busy_} !== 2'b11 || bus_a.master_read_data !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL direct_hold: ready_,busy_ %b data %h expected 11 deadbeef",
               {bus_a.master_ready_, bus_a.busy_}, bus_a.master_read_data);
    end
  endtask

  task automatic test_priority();
    idle_a();
    bus_a.slave_read_data[2*DW +: DW] = 32'h0000_0002;
    bus_a.slave_read_data[5*DW +: DW] = 32'h0000_0005;
    bus_a.slave_chip_select_[2] = 1'b0;
    bus_a.slave_chip_select_[5] = 1'b0;
    bus_a.master_request_       = 1'b0;
    sb_q.push_back('{data: 32'h0000_0002, err_n: 1'b1});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_vec++;
      if ({bus_a.master_ready_, bus_a.busy_} !== 2'b10) begin
        n_bad++;
        $display("FAIL prio_wait%0d: ready_,busy_ got %b expected 10", j,
                 {bus_a.master_ready_, bus_a.busy_});
      end
      if (j == 0) bus_a.slave_ready_[5] = 1'b0;
      if (j == 1) bus_a.slave_chip_select_ = '1;
      if (j == 3) bus_a.slave_ready_[2] = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if ({bus_a.master_ready_, bus_a.busy_} !== 2'b01) begin
      n_bad++;
      $display("FAIL prio_resp: ready_,busy_ got %b expected 01",
               {bus_a.master_ready_, bus_a.busy_});
    end
    idle_a();
    @(negedge clk);
  endtask

  task automatic test_decode_miss();
    idle_a();
    bus_a.master_request_ = 1'b0;
    sb_q.push_back('{data: 32'h0, err_n: 1'b0});
    @(negedge clk);
    n_vec++;
    if ({bus_a.master_ready_, bus_a.master_error_, bus_a.busy_} !== 3'b001) begin
      n_bad++;
      $display("FAIL miss_resp: ready_,error_,busy_ got %b expected 001",
               {bus_a.master_ready_, bus_a.master_error_, bus_a.busy_});
    end
    idle_a();
    @(negedge clk);
    n_vec++;
    if ({bus_a.master_ready_, bus_a.master_error_} !== 2'b11) begin
      n_bad++;
      $display("FAIL miss_after: ready_,error_ got %b expected 11",
               {bus_a.master_ready_, bus_a.master_error_});
    end
  endtask

  // late_ready: drive slave 0 ready so it lands on the timeout edge.
  task automatic test_timeout(input bit late_ready, input logic [DW-1:0] d);
    idle_a();
    bus_a.slave_read_data[0 +: DW] = d;
    bus_a.slave_chip_select_[0] = 1'b0;
    bus_a.master_request_       = 1'b0;
    if (late_ready) sb_q.push_back('{data: d, err_n: 1'b1});
    else            sb_q.push_back('{data: 32'h0, err_n: 1'b0});
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_vec++;
      if ({bus_a.master_ready_, bus_a.busy_} !== 2'b10) begin
        n_bad++;
        $display("FAIL tmo_wait%0d: ready_,busy_ got %b expected 10", j,
                 {bus_a.master_ready_, bus_a.busy_});
      end
      if (late_ready && j == 7) bus_a.slave_ready_[0] = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if ({bus_a.master_ready_, bus_a.master_error_, bus_a.busy_} !== {1'b0, late_ready, 1'b1}) begin
      n_bad++;
      $display("FAIL tmo_resp: ready_,error_,busy_ got %b expected %b",
               {bus_a.master_ready_, bus_a.master_error_, bus_a.busy_}, {1'b0, late_ready, 1'b1});
    end
    idle_a();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    idle_a();
    bus_a.slave_read_data[4*DW +: DW] = 32'h4444_0004;
    bus_a.slave_read_data[6*DW +: DW] = 32'h6666_0006;
    bus_a.slave_chip_select_[4] = 1'b0;
    bus_a.slave_ready_[4]       = 1'b0;
    bus_a.master_request_       = 1'b0;
    sb_q.push_back('{data: 32'h4444_0004, err_n: 1'b1});
    sb_q.push_back('{data: 32'h6666_0006, err_n: 1'b1});
    @(negedge clk);
    n_vec++;
    if (bus_a.master_ready_ !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first: ready_ got %b expected 0", bus_a.master_ready_);
    end
    bus_a.slave_chip_select_ = '1;
    bus_a.slave_ready_       = '1;
    bus_a.slave_chip_select_[6] = 1'b0;
    bus_a.slave_ready_[6]       = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_a.master_ready_ !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_gap: ready_ got %b expected 1", bus_a.master_ready_);
    end
    @(negedge clk);
    n_vec++;
    if (bus_a.master_ready_ !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: ready_ got %b expected 0", bus_a.master_ready_);
    end
    idle_a();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    idle_a();
    bus_a.slave_chip_select_[1] = 1'b0;
    bus_a.master_request_       = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_ = 1'b0;
    #1;
    n_vec++;
    if ({bus_a.master_ready_, bus_a.master_error_, bus_a.busy_} !== 3'b111 ||
        bus_a.master_read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: strobes %b data %h expected 111 0",
               {bus_a.master_ready_, bus_a.master_error_, bus_a.busy_}, bus_a.master_read_data);
    end
    idle_a();
    @(negedge clk);
    reset_ = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_vec++;
      if ({bus_a.master_ready_, bus_a.busy_} !== 2'b11) begin
        n_bad++;
        $display("FAIL post_reset%0d: ready_,busy_ got %b expected 11", j,
                 {bus_a.master_ready_, bus_a.busy_});
      end
    end
  endtask

  task automatic test_abort();
    idle_a();
    bus_a.slave_read_data[1*DW +: DW] = 32'h0000_0B0B;
    bus_a.slave_chip_select_[1] = 1'b0;
    bus_a.master_request_       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (bus_a.busy_ !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: busy_ got %b expected 0", bus_a.busy_);
    end
    bus_a.master_request_ = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      n_vec++;
      if ({bus_a.master_ready_, bus_a.busy_} !== 2'b11) begin
        n_bad++;
        $display("FAIL abort_idle%0d: ready_,busy_ got %b expected 11", j,
                 {bus_a.master_ready_, bus_a.busy_});
      end
    end
    bus_a.slave_ready_[1] = 1'b0;
    bus_a.master_request_ = 1'b0;
    sb_q.push_back('{data: 32'h0000_0B0B, err_n: 1'b1});
    @(negedge clk);
    n_vec++;
    if (bus_a.master_ready_ !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_next: ready_ got %b expected 0", bus_a.master_ready_);
    end
    idle_a();
    @(negedge clk);
  endtask

  task automatic test_no_timeout();
    int ready_low;
    int busy_high;
    ready_low = 0;
    busy_high = 0;
    idle_b();
    bus_b.slave_chip_select_[0] = 1'b0;
    bus_b.master_request_       = 1'b0;
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk);
      if (!bus_b.master_ready_) ready_low++;
      if (bus_b.busy_) busy_high++;
    end
    n_vec++;
    if (ready_low !== 0) begin
      n_bad++;
      $display("FAIL notmo_ready: %0d response cycles expected 0", ready_low);
    end
    n_vec++;
    if (busy_high !== 0) begin
      n_bad++;
      $display("FAIL notmo_busy: %0d non-busy cycles expected 0", busy_high);
    end
    idle_b();
    repeat (2) @(negedge clk);
    bus_b.slave_read_data[7*DW +: DW] = 32'h7777_0077;
    bus_b.slave_chip_select_[7] = 1'b0;
    bus_b.slave_ready_[7]       = 1'b0;
    bus_b.master_request_       = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus_b.master_ready_, bus_b.master_error_} !== 2'b01 ||
        bus_b.master_read_data !== 32'h7777_0077) begin
      n_bad++;
      $display("FAIL notmo_after: ready_,error_ %b data %h expected 01 77770077",
               {bus_b.master_ready_, bus_b.master_error_}, bus_b.master_read_data);
    end
    idle_b();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_direct();
    test_priority();
    test_decode_miss();
    test_timeout(1'b0, 32'h0000_1234);
    test_timeout(1'b1, 32'hA5A5_0008);
    test_back_to_back();
    test_reset_mid_wait();
    test_abort();
    test_no_timeout();
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_leftover: %0d responses never seen expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
